// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// Shared 640x480@60 raster constants and sync polarity, imported by the
// timing stage and by the pattern generators.
package vga_pkg;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = 800;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = 525;

  localparam logic SYNC_POL = 1'b0;

  // Frames-per-advance mask: speed s advances once every 2^s frames.
  function automatic logic [2:0] speed_mask(input logic [1:0] speed);
    case (speed)
      2'd0:    speed_mask = 3'b000;
      2'd1:    speed_mask = 3'b001;
      2'd2:    speed_mask = 3'b011;
      default: speed_mask = 3'b111;
    endcase
  endfunction
endpackage

// File: rtl/frame_pacer.sv
`timescale 1ns/1ps
// Animation pacing: frame divider, pause, single-step capture and the
// one-cycle next_frame pulse aligned to the start of vertical blanking.
module frame_pacer
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       blank_start,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       step,
  output logic       next_frame
);
  logic [2:0] fdiv_q, fdiv_d;
  logic       step_q, step_d;
  logic       step_pend_q, step_pend_d;
  logic       next_frame_q, next_frame_d;
  logic       step_rise;
  logic       div_evt;
  logic [2:0] mask;

  always_comb begin
    mask        = speed_mask(speed);
    step_rise   = step & ~step_q;
    div_evt     = ((fdiv_q & mask) == mask);
    step_d      = step;
    fdiv_d      = fdiv_q;
    step_pend_d = step_pend_q | step_rise;
    next_frame_d = 1'b0;
    // blank_start is the cycle before (0, V_VISIBLE); the registered pulse
    // lands on the blanking point itself. An edge seen here waits a frame.
    if (blank_start) begin
      next_frame_d = (div_evt & ~pause) | step_pend_q;
      step_pend_d  = step_rise;
      if (!pause) fdiv_d = fdiv_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fdiv_q       <= '0;
      step_q       <= 1'b0;
      step_pend_q  <= 1'b0;
      next_frame_q <= 1'b0;
    end else begin
      fdiv_q       <= fdiv_d;
      step_q       <= step_d;
      step_pend_q  <= step_pend_d;
      next_frame_q <= next_frame_d;
    end
  end

  assign next_frame = next_frame_q;
endmodule

// File: rtl/vga_timing_pacer.sv
`timescale 1ns/1ps
// VGA raster counters with registered active/sync decodes, plus the frame
// pacer that generates the animation advance pulse.
module vga_timing_pacer
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       step,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       next_frame
);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_start;

  // Decodes use the next counter value so they line up with x/y once registered.
  always_comb begin
    x_d = (x_q == H_LAST) ? '0 : x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    active_d    = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d     = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    blank_start = (x_d == '0) && (y_d == V_VIS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b1;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  frame_pacer u_pacer (
    .clk         (clk),
    .rst         (rst),
    .blank_start (blank_start),
    .speed       (speed),
    .pause       (pause),
    .step        (step),
    .next_frame  (next_frame)
  );

  assign x      = x_q;
  assign y      = y_q;
  assign active = active_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
endmodule

// File: tb/tb_vga_timing_pacer.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_timing_pacer on a shrunken raster (15x12, frame
// of 180 cycles) so divider, pause, step and reset cases fit in a short run.
module tb_vga_timing_pacer;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = 15;          // 8+2+3+2
  localparam int VT = 12;          // 6+2+2+2
  localparam int FR = 180;         // cycles per frame
  localparam int B0 = 90;          // cycle index of (0,6) after reset release

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] speed = 2'd0;
  logic       pause = 1'b0;
  logic       step  = 1'b0;
  logic [9:0] x, y;
  logic       active, hsync, vsync, next_frame;

  int cyc;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int ex, ey;

  vga_timing_pacer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .speed(speed), .pause(pause), .step(step),
    .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .next_frame(next_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int bp(input int n);
    return B0 + FR * n;
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: raster reference from the cycle count, pulse scoreboard from exp_q.
  always @(negedge clk) begin
    ex = cyc % HT;
    ey = (cyc / HT) % VT;
    check("x", int'(x), ex);
    check("y", int'(y), ey);
    check("active", int'(active), int'((ex < 8) && (ey < 6)));
    check("hsync", int'(hsync), int'(!((ex >= 10) && (ex <= 12))));
    check("vsync", int'(vsync), int'(!((ey >= 8) && (ey <= 9))));
    if (next_frame) begin
      if (exp_q.size() == 0) check("unexpected_pulse_cyc", cyc, -1);
      else check("pulse_cyc", cyc, exp_q.pop_front());
    end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      check("missing_pulse_cyc", -1, exp_q.pop_front());
    end
  end

  task automatic at_cyc(input int c);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc < c && guard < 20000);
    if (guard >= 20000) check("wait_timeout", cyc, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // speed 0: a pulse every frame
    exp_q.push_back(bp(0));
    exp_q.push_back(bp(1));
    exp_q.push_back(bp(2));
    exp_q.push_back(bp(3));

    // speed 3 from fdiv=4: fires when fdiv==7, i.e. frames 7 and 15
    at_cyc(bp(3) + 5);
    speed = 2'd3;
    exp_q.push_back(bp(7));
    exp_q.push_back(bp(15));

    // pause: frames 16..18 silent, then a double step yields one pulse
    at_cyc(bp(15) + 5);
    speed = 2'd0;
    pause = 1'b1;
    at_cyc(bp(18) + 100);
    step = 1'b1;
    exp_q.push_back(bp(19));
    at_cyc(bp(18) + 102);
    step = 1'b0;
    at_cyc(bp(18) + 105);
    step = 1'b1;
    at_cyc(bp(18) + 107);
    step = 1'b0;

    // step edge in the blanking-point cycle is serviced one frame later
    at_cyc(bp(20));
    step = 1'b1;
    exp_q.push_back(bp(21));
    at_cyc(bp(20) + 2);
    step = 1'b0;

    // step coinciding with a divider event: one pulse, pend cleared
    at_cyc(bp(22) + 5);
    pause = 1'b0;
    exp_q.push_back(bp(23));
    at_cyc(bp(22) + 50);
    step = 1'b1;
    at_cyc(bp(22) + 52);
    step = 1'b0;
    at_cyc(bp(23) + 5);
    pause = 1'b1;

    // reset mid-frame with a step pending: pend and fdiv discarded
    at_cyc(bp(24) + 30);
    step = 1'b1;
    at_cyc(bp(24) + 32);
    step = 1'b0;
    at_cyc(bp(24) + 60);
    rst = 1'b1;
    exp_q.delete();
    speed = 2'd1;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(bp(1));
    exp_q.push_back(bp(3));

    at_cyc(bp(3) + 20);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
